plic_gateway: RTL and testbench
===============================

# plic_gateway

Per-source interrupt gateway sitting between peripheral interrupt wires (UART, GPIO, SDC, …) and the PLIC core's request inputs. Each source is level- or rising-edge-triggered, selectable at run time. The gateway enforces one outstanding request per source: after forwarding a request it suppresses further requests from that source until the PLIC core reports claim and then completion of that source ID. In edge mode, edges arriving while a request is outstanding are counted and replayed one at a time, with saturation and a sticky overflow flag.

## Interface
- NSRC, 31: number of sources, IDs 1..NSRC; 1 ≤ NSRC ≤ 63.
- CNTW, 4: width of the per-source edge counter.

- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- SrcIn  in  [NSRC:1]  raw interrupt lines, already synchronized to PCLK.
- EdgeMode  in  [NSRC:1]  per source: 1 = rising-edge, 0 = level.
- Claim  in  1  one-cycle pulse: the PLIC core has claimed ClaimID.
- ClaimID  in  6  ID being claimed.
- Complete  in  1  one-cycle pulse: the PLIC core has completed CompleteID.
- CompleteID  in  6  ID being completed.
- OvfClr  in  1  clears all Overflow bits.
- Request  out  [NSRC:1]  registered request to the PLIC core, per source.
- InService  out  [NSRC:1]  registered; 1 while the source is claimed and not yet completed.
- Overflow  out  [NSRC:1]  registered sticky edge-counter saturation flag.

## Operation
- Per-source FSM with states IDLE, REQ and BUSY. Request[i] = (state==REQ); InService[i] = (state==BUSY).
- Edge detect: SrcPrev[i] is a register of SrcIn[i]; edge[i] = SrcIn[i] & ~SrcPrev[i].
- Counter cnt[i] holds edges not yet forwarded.
  - Each edge adds 1.
  - Saturates at 2^CNTW−1. An edge arriving at saturation sets Overflow[i].
  - While EdgeMode[i]=0, cnt[i] is forced to 0.
- IDLE:
  - Level mode: SrcIn[i]=1 → REQ.
  - Edge mode: (cnt[i]≠0 | edge[i]) → REQ. In the same cycle cnt[i] ← cnt[i] + edge[i] − 1, so the consumed edge is removed.
  - Otherwise stay in IDLE.
- REQ:
  - Claim & ClaimID==i → BUSY.
  - Request stays high until the claim, regardless of SrcIn.
  - Edges in this state increment cnt[i].
- BUSY: Complete & CompleteID==i → IDLE. Edges increment cnt[i].
- Ignored events:
  - Claim for a source not in REQ.
  - Complete for a source not in BUSY.
  - ID 0, or ID > NSRC.
  - Mismatched IDs; no other source is affected.
- Claim and Complete in the same cycle are decoded independently. Since a given source cannot be in both REQ and BUSY, at most one of them acts on that source.
- EdgeMode changes are sampled every cycle. A change never aborts REQ or BUSY; the new mode governs the next IDLE decision.
- Overflow: set has priority over OvfClr in the same cycle. OvfClr clears all other bits.

## Timing
- Reset, asynchronous and taking effect immediately:
  - All states IDLE.
  - cnt, SrcPrev, Request, InService and Overflow all 0.
- A line that is high in the first cycle after reset counts as an edge, because SrcPrev=0.
- Latency from SrcIn rising (sampled at PCLK edge n) to Request=1: visible after edge n, i.e. 1 cycle.
- Claim sampled at edge n: Request=0 and InService=1 after edge n.
- Complete sampled at edge n: InService=0 after edge n. Earliest re-request is after edge n+1, a mandatory 1-cycle IDLE gap.
- Back-to-back edges are resolved at 1 edge per cycle; SrcIn must be low for ≥1 cycle between edges.
- Counter update per cycle = +edge − consume, clamped to [0, 2^CNTW−1]. Edge and consume in the same cycle leave cnt unchanged.

## Test plan
- Level source 3, SrcIn[3]=1 held → Request[3]=1 after 1 cycle. Claim ID 3 → InService[3]=1, Request[3]=0. Complete ID 3 → IDLE for 1 cycle, then Request[3]=1 again because the level is still high. Drop SrcIn first → no re-request.
- Edge source 5: 3 pulses while BUSY → cnt=3. Each Complete/Claim cycle re-raises Request[5] after the 1-cycle gap. Exactly 3 further requests occur, then idle.
- Edge source 5, CNTW=4: 16 pulses while BUSY → cnt=15, Overflow[5]=1. OvfClr in the same cycle as a 17th edge → Overflow[5] stays 1. OvfClr alone → 0.
- Claim ID 0, ID 40 (NSRC=31), and ID 4 while source 4 is IDLE → no state change anywhere. Complete ID 7 while 7 is in REQ → ignored; Request[7] stays 1.
- Source 2 in REQ and source 6 in BUSY; Claim ID 2 and Complete ID 6 in the same cycle → next cycle source 2 is BUSY and source 6 is IDLE.
- Assert PRESETn=0 mid-BUSY with cnt=5 → outputs go to 0 immediately, without waiting for a clock edge. After release, SrcIn held high yields an edge → Request=1 one cycle later.

Source files
------------

// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
// Module   : plic_gateway
// Purpose  : Per-source interrupt gateway in front of the PLIC core. Each
//            source is level- or rising-edge-triggered, selectable at run
//            time. A source may have only one request outstanding. Once a
//            request is forwarded, the source is blocked until the core
//            claims and then completes that ID. In edge mode, edges that
//            arrive while a request is outstanding are counted and replayed
//            one at a time. The count saturates and sets a sticky overflow
//            flag.
// Ports    : PCLK        - clock
//            PRESETn     - asynchronous active-low reset
//            SrcIn       - raw interrupt lines (already synchronised), [NSRC:1]
//            EdgeMode    - per source: 1 = rising edge, 0 = level
//            Claim/ClaimID       - one-cycle claim pulse and claimed ID
//            Complete/CompleteID - one-cycle completion pulse and ID
//            OvfClr      - clears every Overflow bit
//            Request     - registered request to the PLIC core
//            InService   - registered; source claimed and not yet completed
//            Overflow    - registered sticky edge-counter saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module plic_gateway #(
    parameter int NSRC = 31,
    parameter int CNTW = 4
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic [NSRC:1]   SrcIn,
    input  logic [NSRC:1]   EdgeMode,
    input  logic            Claim,
    input  logic [5:0]      ClaimID,
    input  logic            Complete,
    input  logic [5:0]      CompleteID,
    input  logic            OvfClr,
    output logic [NSRC:1]   Request,
    output logic [NSRC:1]   InService,
    output logic [NSRC:1]   Overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    localparam logic [CNTW-1:0] C_CNT_MAX = {CNTW{1'b1}};

    for (genvar i = 1; i <= NSRC; i++) begin : g_src
        state_e          state_q, state_d;
        logic [CNTW-1:0] cnt_q, cnt_d;
        logic            prev_q;
        logic            req_q;
        logic            busy_q;
        logic            ovf_q, ovf_d;
        logic            rise_w;
        logic            consume_w;
        logic            ovf_set_w;
        logic            claim_hit_w;
        logic            complete_hit_w;

        assign rise_w         = SrcIn[i] & ~prev_q;
        // Source IDs start at 1, so ID 0 and IDs above NSRC never match.
        assign claim_hit_w    = Claim    & (ClaimID    == 6'(i));
        assign complete_hit_w = Complete & (CompleteID == 6'(i));

        // Next-state logic. consume_w marks the IDLE->REQ transition that
        // uses up one pending edge in edge mode.
        always_comb begin
            state_d   = state_q;
            consume_w = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (EdgeMode[i]) begin
                        if ((cnt_q != '0) || rise_w) begin
                            state_d   = ST_REQ;
                            consume_w = 1'b1;
                        end
                    end else if (SrcIn[i]) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (claim_hit_w) begin
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (complete_hit_w) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Pending-edge counter: +edge - consume, clamped. An edge that is
        // also consumed in the same cycle leaves the count unchanged. Only
        // an increment that would pass the maximum counts as overflow.
        always_comb begin
            cnt_d     = cnt_q;
            ovf_set_w = 1'b0;
            if (!EdgeMode[i]) begin
                cnt_d = '0;
            end else if (rise_w && !consume_w) begin
                if (cnt_q == C_CNT_MAX) begin
                    ovf_set_w = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end else if (!rise_w && consume_w) begin
                cnt_d = cnt_q - CNTW'(1);
            end
        end

        // Setting the flag takes priority over a clear in the same cycle.
        always_comb begin
            ovf_d = ovf_q & ~OvfClr;
            if (ovf_set_w) begin
                ovf_d = 1'b1;
            end
        end

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                prev_q  <= 1'b0;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                prev_q  <= SrcIn[i];
                req_q   <= (state_d == ST_REQ);
                busy_q  <= (state_d == ST_BUSY);
                ovf_q   <= ovf_d;
            end
        end

        assign Request[i]   = req_q;
        assign InService[i] = busy_q;
        assign Overflow[i]  = ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_plic_gateway.sv
`default_nettype none
// ============================================================================
// Module   : tb_plic_gateway
// Purpose  : Self-checking bench for plic_gateway. A behavioural gateway
//            model tracks each source's outstanding request, service status,
//            pending-edge count and overflow flag. Outputs are compared every
//            cycle. Directed literal checks pin down the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plic_gateway;
    localparam int NSRC = 31;
    localparam int CNTW = 4;
    localparam int MAXC = (1 << CNTW) - 1;

    logic            clk        = 1'b0;
    logic            PRESETn    = 1'b0;
    logic [NSRC:1]   SrcIn      = '0;
    logic [NSRC:1]   EdgeMode   = '0;
    logic            Claim      = 1'b0;
    logic [5:0]      ClaimID    = '0;
    logic            Complete   = 1'b0;
    logic [5:0]      CompleteID = '0;
    logic            OvfClr     = 1'b0;
    logic [NSRC:1]   Request;
    logic [NSRC:1]   InService;
    logic [NSRC:1]   Overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    plic_gateway #(.NSRC(NSRC), .CNTW(CNTW)) dut (
        .PCLK       (clk),
        .PRESETn    (PRESETn),
        .SrcIn      (SrcIn),
        .EdgeMode   (EdgeMode),
        .Claim      (Claim),
        .ClaimID    (ClaimID),
        .Complete   (Complete),
        .CompleteID (CompleteID),
        .OvfClr     (OvfClr),
        .Request    (Request),
        .InService  (InService),
        .Overflow   (Overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_req  [1:NSRC];
    bit m_busy [1:NSRC];
    bit m_ovf  [1:NSRC];
    bit m_prev [1:NSRC];
    int m_cnt  [1:NSRC];

    always @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 1; i <= NSRC; i++) begin
                m_req[i] = 0; m_busy[i] = 0; m_ovf[i] = 0;
                m_prev[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            for (int i = 1; i <= NSRC; i++) begin
                bit e, used;
                int n;
                e    = SrcIn[i] && !m_prev[i];
                used = 0;
                if (!m_req[i] && !m_busy[i]) begin
                    if (EdgeMode[i]) begin
                        if (m_cnt[i] > 0 || e) begin
                            m_req[i] = 1;
                            used     = 1;
                        end
                    end else if (SrcIn[i]) begin
                        m_req[i] = 1;
                    end
                end else if (m_req[i]) begin
                    if (Claim && int'(ClaimID) == i) begin
                        m_req[i]  = 0;
                        m_busy[i] = 1;
                    end
                end else if (Complete && int'(CompleteID) == i) begin
                    m_busy[i] = 0;
                end
                if (!EdgeMode[i]) begin
                    m_cnt[i] = 0;
                end else begin
                    n = m_cnt[i] + int'(e) - int'(used);
                    if (n > MAXC) begin
                        n        = MAXC;
                        m_ovf[i] = 1;
                    end else if (OvfClr) begin
                        m_ovf[i] = 0;
                    end
                    m_cnt[i] = n;
                end
                if (!EdgeMode[i] && OvfClr) m_ovf[i] = 0;
                m_prev[i] = SrcIn[i];
            end
        end
    end

    // ---------------- checking ----------------
    task automatic cmp_vec(input string nm, input logic [NSRC:1] act, input logic [NSRC:1] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [NSRC:1] er, eb, eo;
        for (int i = 1; i <= NSRC; i++) begin
            er[i] = m_req[i];
            eb[i] = m_busy[i];
            eo[i] = m_ovf[i];
        end
        cmp_vec("model_Request",   Request,   er);
        cmp_vec("model_InService", InService, eb);
        cmp_vec("model_Overflow",  Overflow,  eo);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i);
        SrcIn[i] = 1'b1; tick();
        SrcIn[i] = 1'b0; tick();
    endtask

    task automatic do_claim(input int id);
        Claim = 1'b1; ClaimID = 6'(id); tick();
        Claim = 1'b0; ClaimID = '0;
    endtask

    task automatic do_complete(input int id);
        Complete = 1'b1; CompleteID = 6'(id); tick();
        Complete = 1'b0; CompleteID = '0;
    endtask

    initial begin
        EdgeMode[5] = 1'b1;
        repeat (2) @(posedge clk);
        #1 PRESETn = 1'b1;
        tick();
        cmp_vec("reset_Request",   Request,   '0);
        cmp_vec("reset_InService", InService, '0);
        cmp_vec("reset_Overflow",  Overflow,  '0);

        // Level source 3
        SrcIn[3] = 1'b1; tick();
        chk("lvl_req", Request[3], 1'b1);
        do_claim(3);
        chk("lvl_claim_insvc", InService[3], 1'b1);
        chk("lvl_claim_req",   Request[3],   1'b0);
        do_complete(3);
        chk("lvl_gap_insvc", InService[3], 1'b0);
        chk("lvl_gap_req",   Request[3],   1'b0);
        tick();
        chk("lvl_rereq", Request[3], 1'b1);
        do_claim(3);
        SrcIn[3] = 1'b0;
        do_complete(3);
        tick(); tick();
        chk("lvl_no_rereq", Request[3], 1'b0);

        // Edge source 5: three edges queued while busy
        SrcIn[5] = 1'b1; tick(); SrcIn[5] = 1'b0;
        chk("edge_first_req", Request[5], 1'b1);
        do_claim(5);
        chk("edge_busy", InService[5], 1'b1);
        for (int k = 0; k < 3; k++) pulse(5);
        for (int k = 0; k < 3; k++) begin
            do_complete(5);
            chk("edge_gap", Request[5], 1'b0);
            tick();
            chk("edge_replay", Request[5], 1'b1);
            do_claim(5);
        end
        do_complete(5);
        tick(); tick();
        chk("edge_drained_req",   Request[5],   1'b0);
        chk("edge_drained_insvc", InService[5], 1'b0);

        // Saturation / overflow on source 5
        SrcIn[5] = 1'b1; tick(); SrcIn[5] = 1'b0;
        do_claim(5);
        for (int k = 0; k < 15; k++) pulse(5);
        chk("ovf_not_yet", Overflow[5], 1'b0);
        pulse(5);
        chk("ovf_set", Overflow[5], 1'b1);
        SrcIn[5] = 1'b1; OvfClr = 1'b1; tick();
        SrcIn[5] = 1'b0; OvfClr = 1'b0;
        chk("ovf_set_beats_clr", Overflow[5], 1'b1);
        tick();
        OvfClr = 1'b1; tick(); OvfClr = 1'b0;
        chk("ovf_cleared", Overflow[5], 1'b0);
        EdgeMode[5] = 1'b0; tick();
        do_complete(5);
        tick();
        chk("mode_switch_no_req", Request[5], 1'b0);
        EdgeMode[5] = 1'b1;

        // Ignored claims / completes
        SrcIn[7] = 1'b1; tick();
        do_claim(0);
        do_claim(40);
        do_claim(4);
        chk("ign_req7", Request[7], 1'b1);
        cmp_vec("ign_insvc_all", InService, '0);
        do_complete(7);
        chk("ign_cmp_req7",   Request[7],   1'b1);
        chk("ign_cmp_insvc7", InService[7], 1'b0);
        do_claim(7);
        SrcIn[7] = 1'b0;
        do_complete(7);
        tick();

        // Simultaneous claim of 2 and complete of 6
        SrcIn[6] = 1'b1; tick();
        do_claim(6);
        SrcIn[6] = 1'b0;
        SrcIn[2] = 1'b1; tick();
        chk("sim_req2", Request[2], 1'b1);
        Claim = 1'b1; ClaimID = 6'd2; Complete = 1'b1; CompleteID = 6'd6; tick();
        Claim = 1'b0; ClaimID = '0; Complete = 1'b0; CompleteID = '0;
        chk("sim_insvc2", InService[2], 1'b1);
        chk("sim_req2_off", Request[2], 1'b0);
        chk("sim_insvc6", InService[6], 1'b0);
        SrcIn[2] = 1'b0;
        do_complete(2);
        tick();

        // Asynchronous reset in the middle of BUSY with five edges pending
        SrcIn[5] = 1'b1; tick(); SrcIn[5] = 1'b0;
        do_claim(5);
        for (int k = 0; k < 5; k++) pulse(5);
        chk("rst_pre_busy", InService[5], 1'b1);
        SrcIn[5] = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        cmp_vec("rst_async_Request",   Request,   '0);
        cmp_vec("rst_async_InService", InService, '0);
        cmp_vec("rst_async_Overflow",  Overflow,  '0);
        @(posedge clk);
        #1 PRESETn = 1'b1;
        tick();
        chk("rst_edge_req", Request[5], 1'b1);
        SrcIn[5] = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
